// File: rtl/chacha_pkg.sv
// Shared ChaCha20 constants, state word layout and job record for the block feeder.
package chacha_pkg;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  localparam int CONST0 = 0;
  localparam int KEY0   = 4;
  localparam int CTR    = 12;
  localparam int NONCE0 = 13;

  typedef struct packed {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
  } job_t;

  // Word i of the 512-bit state lives at [511-32i -: 32].
  function automatic logic [511:0] init_state(input job_t j, input logic [31:0] ctr);
    logic [511:0] st;
    st = '0;
    st[511-32*(CONST0+0) -: 32] = SIGMA0;
    st[511-32*(CONST0+1) -: 32] = SIGMA1;
    st[511-32*(CONST0+2) -: 32] = SIGMA2;
    st[511-32*(CONST0+3) -: 32] = SIGMA3;
    for (int k = 0; k < 8; k++) st[511-32*(KEY0+k) -: 32] = j.key[255-32*k -: 32];
    st[511-32*CTR -: 32] = ctr;
    for (int n = 0; n < 3; n++) st[511-32*(NONCE0+n) -: 32] = j.nonce[95-32*n -: 32];
    return st;
  endfunction

endpackage

// File: rtl/chacha_tag_delay.sv
// Fixed-depth shift register carrying the {valid, last, idx} sideband alongside the core.
module chacha_tag_delay
  import chacha_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/chacha_block_feeder.sv
// Expands one keystream job into per-block ChaCha20 initial states under credit flow control.
// Optional counter-wrap truncation and error flag: CHACHA_CTR_WRAP_CHK_EN.
module chacha_block_feeder
  import chacha_pkg::*;
#(
  parameter int PIPE_LAT = 12,
  parameter int CNT_W    = 16,
  parameter int CREDITS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [255:0]     job_key,
  input  logic [95:0]      job_nonce,
  input  logic [31:0]      job_ctr,
  input  logic [CNT_W-1:0] job_nblk,
  output logic [511:0]     state_in,
  output logic             ks_valid,
  output logic             ks_last,
  output logic [CNT_W-1:0] ks_idx,
  input  logic             ks_pop,
  output logic             job_err
);

  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam int TAG_W  = CNT_W + 2;

  typedef enum logic {IDLE, ISSUE} fsm_t;

  fsm_t              fsm, fsm_nxt;
  job_t              job;
  logic [CNT_W-1:0]  nblk, idx, nblk_acc;
  logic [CRED_W-1:0] credit;
  logic              accept, issue, last_blk, pop_ok;
  logic [TAG_W-1:0]  tag_p0, tag_out;

  assign job_ready = (fsm == IDLE) && !rst;
  assign accept    = job_valid && job_ready;
  assign last_blk  = (idx == nblk - 1'b1);
  assign pop_ok    = ks_pop && (credit != CRED_W'(CREDITS));

`ifdef CHACHA_CTR_WRAP_CHK_EN
  // Clamp the block count so the 32-bit counter never passes 2^32-1; MSB flags truncation.
  function automatic logic [CNT_W:0] clamp_nblk(input logic [31:0] ctr, input logic [CNT_W-1:0] n);
    logic [32:0] room;
    room = 33'h1_0000_0000 - {1'b0, ctr};
    if (33'(n) > room) return {1'b1, CNT_W'(room)};
    return {1'b0, n};
  endfunction

  logic wrap, err;
  assign {wrap, nblk_acc} = clamp_nblk(job_ctr, job_nblk);

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (accept) err <= wrap;
  end
  assign job_err = err;
`else
  assign nblk_acc = job_nblk;
  assign job_err  = 1'b0;
`endif

  always_comb begin
    fsm_nxt = fsm;
    issue   = 1'b0;
    case (fsm)
      IDLE:  if (accept && nblk_acc != '0) fsm_nxt = ISSUE;
      ISSUE: begin
        issue = (credit != '0);
        if (issue && last_blk) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      job  <= '{key: job_key, nonce: job_nonce, ctr: job_ctr};
      nblk <= nblk_acc;
    end
  end

  // Stage p0: issued state and its tag, registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      credit   <= CRED_W'(CREDITS);
      idx      <= '0;
      state_in <= '0;
      tag_p0   <= '0;
    end else begin
      fsm <= fsm_nxt;
      if (accept) idx <= '0;
      else if (issue) idx <= idx + 1'b1;
      if (issue && !ks_pop) credit <= credit - 1'b1;
      else if (!issue && pop_ok) credit <= credit + 1'b1;
      if (issue) state_in <= init_state(job, job.ctr + 32'(idx));
      tag_p0 <= issue ? {1'b1, last_blk, idx} : '0;
    end
  end

  chacha_tag_delay #(.DEPTH(PIPE_LAT), .W(TAG_W)) u_tag_delay (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_p0),
    .dout (tag_out)
  );

  assign {ks_valid, ks_last, ks_idx} = tag_out;

endmodule
